mem_rr_arbiter: RTL

- Shares one single-port word memory (the mem-side port of the AXI4-Lite-to-memory bridge) between NUM_REQ independent requesters.
- Typical requesters: several bridge instances, or a bridge plus a DMA/debug master.
- Round-robin fair, one access per cycle, registered memory-side outputs.
- Read data is routed back to the originating requester with fixed latency.

---
 rtl/mem_rr_arbiter_pkg.sv | 19 +
 rtl/mem_rr_arbiter_if.sv | 36 +++
 rtl/mem_rr_arbiter_rr_pick.sv | 35 +++
 rtl/mem_rr_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/mem_rr_arbiter_pkg.sv
// mem_arb_pkg: shared constants and helpers for mem_rr_arbiter.
//   MEM_RD_LAT  : memory read latency (mem_ren -> mem_rdata), cycles.
//   ARB_RSP_LAT : grant -> rsp_valid latency, cycles.
//   RSP_PIPE_ST : depth of the {valid,id} read-tracking pipe.
//   rsp_ent_w() : bit width of one read-tracking pipe entry.
package mem_arb_pkg;

  localparam int MEM_RD_LAT  = 1;
  localparam int ARB_RSP_LAT = 3;
  // One stage covers the issue register, one covers the memory read
  // latency. The output register supplies the last cycle.
  localparam int RSP_PIPE_ST = ARB_RSP_LAT - 1;

  // A pipe entry is one valid bit plus a requester index.
  function automatic int rsp_ent_w(input int idw);
    return 1 + idw;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if: requester-side and memory-side bus of mem_rr_arbiter.
//   slave  : arbiter view. It takes requests and mem_rdata, and it drives
//            grants, responses and memory commands.
//   master : environment view (requesters plus memory), the reverse.
// Requester i uses req_addr[i*ALEN +: ALEN] and req_wdata[i*DLEN +: DLEN].
interface mem_rr_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ALEN    = 2,
  parameter int DLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_we;
  logic [NUM_REQ*ALEN-1:0] req_addr;
  logic [NUM_REQ*DLEN-1:0] req_wdata;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [DLEN-1:0]         rsp_rdata;
  logic                    mem_wen;
  logic [ALEN-1:0]         mem_waddr;
  logic [DLEN-1:0]         mem_wdata;
  logic                    mem_ren;
  logic [ALEN-1:0]         mem_raddr;
  logic [DLEN-1:0]         mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
           mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
           mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
  );
endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req : candidate request vector
//   ptr : index with the highest priority. The search wraps modulo N.
//   gnt : one-hot grant, all zero when req is empty
//   idx : index of the granted bit (0 when there is no grant)
//   any : a grant was made
module rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin sharing of one single-port word memory
// between NUM_REQ requesters. The block accepts one access per cycle and
// registers all memory-side outputs.
//   clk, rst : clock and synchronous active-high reset
//   bus      : mem_rr_arbiter_if.slave
//              req_valid/req_ready/req_we/req_addr/req_wdata : requests
//              rsp_valid/rsp_rdata : read return, 3 cycles after the grant
//              mem_* : memory port (mem_rdata arrives 1 cycle after mem_ren)
// Optional: MEM_RR_ARBITER_WR_PRIO_EN. When any valid request is a write,
// only the writers take part in the round-robin for that cycle.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ALEN    = 2,
  parameter int DLEN    = 32,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  mem_rr_arbiter_if.slave    bus
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } rsp_ent_t;

  localparam int LAST = RSP_PIPE_ST - 1;

  // The packed 2-D views share the flat bus layout, so slot i is requester i.
  logic [NUM_REQ-1:0][ALEN-1:0] addr_a;
  logic [NUM_REQ-1:0][DLEN-1:0] wdata_a;
  assign addr_a  = bus.req_addr;
  assign wdata_a = bus.req_wdata;

  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gidx;
  logic               gany;
  logic               g_we;

`ifdef MEM_RR_ARBITER_WR_PRIO_EN
  logic [NUM_REQ-1:0] wr_req;
  assign wr_req = bus.req_valid & bus.req_we;
  assign cand   = (|wr_req) ? wr_req : bus.req_valid;
`else
  assign cand   = bus.req_valid;
`endif

  rr_pick #(.N(NUM_REQ), .IDW(IDW)) u_pick (
    .req (cand),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  // Grants depend only on req_valid and ptr. A requester may therefore
  // hold valid while it waits for ready.
  assign bus.req_ready = rst ? '0 : gnt;
  assign g_we          = bus.req_we[gidx];

  logic               mem_wen_q, mem_ren_q;
  logic [ALEN-1:0]    mem_waddr_q, mem_raddr_q;
  logic [DLEN-1:0]    mem_wdata_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DLEN-1:0]    rsp_rdata_q;
  rsp_ent_t           rsp_pipe [RSP_PIPE_ST];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_raddr_q <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      for (int s = 0; s < RSP_PIPE_ST; s++) rsp_pipe[s] <= '0;
    end else begin
      if (gany)
        ptr <= (gidx == IDW'(NUM_REQ - 1)) ? '0 : gidx + IDW'(1);

      // Issue stage. A cycle without a grant leaves both enables low.
      mem_wen_q <= gany & g_we;
      mem_ren_q <= gany & ~g_we;
      if (gany & g_we) begin
        mem_waddr_q <= addr_a[gidx];
        mem_wdata_q <= wdata_a[gidx];
      end
      if (gany & ~g_we)
        mem_raddr_q <= addr_a[gidx];

      // Reads only. Stage 0 lines up with mem_ren and the last stage
      // lines up with mem_rdata.
      rsp_pipe[0] <= '{valid: gany & ~g_we, id: gidx};
      for (int s = 1; s < RSP_PIPE_ST; s++) rsp_pipe[s] <= rsp_pipe[s-1];

      // rsp_rdata holds its value between responses.
      rsp_valid_q <= '0;
      if (rsp_pipe[LAST].valid) begin
        rsp_valid_q[rsp_pipe[LAST].id] <= 1'b1;
        rsp_rdata_q                    <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_raddr = mem_raddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
